watch_time_core: RTL and testbench
==================================

# watch_time_core

Time-keeping and display-source stage of the watch, sitting directly upstream of the display multiplexer. It keeps 24-hour BCD time (HH:MM:SS) advanced by a 1 Hz tick. It provides a button-driven set mode for hours and minutes and encodes all six digits to active-low 7-segment patterns. It also generates the per-digit active-low enables that blink the field being edited.

## Interface
Parameters: none.

- CLK_IN  input  1  system clock; all state on rising edge
- RST_N  input  1  reset; asynchronous, active-low
- TICK_1HZ  input  1  one-cycle pulse, 1 Hz, synchronous to CLK_IN
- TICK_BLINK  input  1  one-cycle pulse, ~4 Hz, synchronous; toggles blink phase
- BTN_MODE  input  1  debounced level, synchronous; rising edge = mode step
- BTN_INC  input  1  debounced level, synchronous; rising edge = increment field
- DISPLAY_S0, DISPLAY_S1, DISPLAY_M0, DISPLAY_M1, DISPLAY_H0, DISPLAY_H1  output  7 each  segment patterns, bit0=a … bit6=g, 0 = segment lit; X0 = units, X1 = tens
- EN_S0, EN_S1, EN_M0, EN_M1, EN_H0, EN_H1  output  1 each  digit enable, 0 = shown, 1 = blanked
- SET_ACTIVE  output  1  1 while in SET_H or SET_M

## Operation
- Time registers: six BCD digits. Ranges: S1 0-5, S0 0-9, M1 0-5, M0 0-9, H1 0-2, H0 0-9 (0-3 when H1=2).
- States: RUN, SET_H, SET_M. Reset state: RUN.
- Button edge detect: each button is registered once. An edge is BTN=1 and previous=0, and acts on that same clock edge.
- RUN:
  - TICK_1HZ increments seconds.
  - 59 s wraps to 00 and carries to minutes.
  - 59 min wraps to 00 and carries to hours.
  - 23:59:59 wraps to 00:00:00.
  - BTN_INC is ignored.
- BTN_MODE edge: RUN→SET_H→SET_M→RUN.
  - Entering SET_H clears seconds to 00.
- SET_H and SET_M:
  - Time is frozen; TICK_1HZ is ignored.
  - A BTN_INC edge increments the selected field only: hours 23→00, minutes 59→00.
  - No carry between fields.
- Blink phase: 1-bit register toggled by TICK_BLINK.
  - Forced to 0 on every state change and on every accepted BTN_INC.
- Enables:
  - RUN: all EN_* = 0.
  - SET_H: EN_H0 = EN_H1 = blink phase; others 0.
  - SET_M: EN_M0 = EN_M1 = blink phase; others 0.
- Segment encoding, active-low, g = bit6: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h.
  - Any unreachable BCD code encodes to 7Fh (blank).
- Simultaneous events:
  - BTN_MODE and BTN_INC edges in the same cycle: MODE wins, INC is discarded.
  - TICK_1HZ and BTN_MODE edge in the same cycle while in RUN: transition to SET_H with seconds = 00; the tick is discarded.
  - TICK_1HZ and BTN_MODE edge in the same cycle while in SET_M: return to RUN; the tick is discarded. Counting resumes at the next tick.

## Timing
- Reset (RST_N low, asynchronous):
  - Time 00:00:00, state RUN, blink phase 0, button history 0.
  - All DISPLAY_* = 40h, all EN_* = 0, SET_ACTIVE = 0.
- Reset assertion mid-edit returns to RUN at 00:00:00 immediately, with no clock edge required.
- Time update: at edge k where TICK_1HZ or a button edge is sampled, the BCD registers, state and SET_ACTIVE update.
- DISPLAY_* and EN_* are registered from the BCD, state and blink registers, so they reflect the change at edge k+1 (one-cycle latency).
- A button held high produces exactly one action. A second action requires BTN low for at least one cycle.
- Back-to-back ticks on consecutive cycles are each counted. No tick spacing is assumed.

## Test plan
- Reset, then 60 TICK_1HZ pulses → seconds 00→59→00, minute 01.
  - Check DISPLAY_S0 = 40h and DISPLAY_M0 = 79h one cycle after the 60th tick.
- Preload 23:59:58 via set mode, then 2 ticks → 23:59:59 then 00:00:00.
  - All six DISPLAY_* = 40h.
- Sequence: MODE edge; INC ×25; MODE edge; INC ×61; MODE edge.
  - Result: time 01:01:00, state RUN, SET_ACTIVE 1→1→0.
  - Ticks during set are ignored.
- In SET_M, pulse TICK_BLINK ×3 → EN_M0/EN_M1 toggle 1,0,1.
  - A subsequent INC forces both to 0 one cycle later.
  - EN_H*, EN_S* stay 0 throughout.
- Same-cycle BTN_MODE and BTN_INC edges in SET_H → state SET_M, hours unchanged.
  - Same-cycle TICK_1HZ and MODE in RUN at 12:34:56 → SET_H at 12:34:00.
- Hold BTN_INC high for 100 cycles in SET_H → exactly one hour increment.
  - Assert RST_N low between clock edges mid-edit → all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/watch_time_core.sv
`default_nettype none
// ============================================================================
// Module   : watch_time_core
// Purpose  : 24-hour BCD time keeper (HH:MM:SS) advanced by a 1 Hz tick, with
//            a two-button set mode for hours and minutes, active-low 7-segment
//            encoding of all six digits and blink enables for the edited field.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK_IN        in   1  system clock, rising edge
//   RST_N         in   1  asynchronous active-low reset
//   TICK_1HZ      in   1  one-cycle 1 Hz pulse
//   TICK_BLINK    in   1  one-cycle ~4 Hz pulse, toggles blink phase
//   BTN_MODE      in   1  debounced level, rising edge steps RUN/SET_H/SET_M
//   BTN_INC       in   1  debounced level, rising edge increments edited field
//   DISPLAY_xx    out  7  segment pattern, bit0=a..bit6=g, 0 = lit
//   EN_xx         out  1  digit enable, 0 = shown, 1 = blanked
//   SET_ACTIVE    out  1  high while in SET_H or SET_M
// ============================================================================
module watch_time_core (
  input  logic       CLK_IN,
  input  logic       RST_N,
  input  logic       TICK_1HZ,
  input  logic       TICK_BLINK,
  input  logic       BTN_MODE,
  input  logic       BTN_INC,
  output logic [6:0] DISPLAY_S0,
  output logic [6:0] DISPLAY_S1,
  output logic [6:0] DISPLAY_M0,
  output logic [6:0] DISPLAY_M1,
  output logic [6:0] DISPLAY_H0,
  output logic [6:0] DISPLAY_H1,
  output logic       EN_S0,
  output logic       EN_S1,
  output logic       EN_M0,
  output logic       EN_M1,
  output logic       EN_H0,
  output logic       EN_H1,
  output logic       SET_ACTIVE
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_s0, r_s1, r_m0, r_m1, r_h0, r_h1;
  logic       r_blink;
  logic       r_mode_d;
  logic       r_inc_d;
  logic       r_set_active;
  logic [6:0] r_disp_s0, r_disp_s1, r_disp_m0, r_disp_m1, r_disp_h0, r_disp_h1;
  logic       r_en_h;
  logic       r_en_m;

  logic       w_mode_edge;
  logic       w_inc_edge;

  // MODE has priority: a coincident INC edge is swallowed.
  assign w_mode_edge = BTN_MODE & ~r_mode_d;
  assign w_inc_edge  = BTN_INC & ~r_inc_d & ~w_mode_edge;

  // Hours roll 23 -> 00; returns {tens, units}.
  function automatic logic [7:0] f_inc_hours(input logic [3:0] h1, input logic [3:0] h0);
    if (h1 == 4'd2 && h0 == 4'd3) f_inc_hours = {4'd0, 4'd0};
    else if (h0 == 4'd9)          f_inc_hours = {h1 + 4'd1, 4'd0};
    else                          f_inc_hours = {h1, h0 + 4'd1};
  endfunction

  // Minutes roll 59 -> 00; returns {tens, units}.
  function automatic logic [7:0] f_inc_minutes(input logic [3:0] m1, input logic [3:0] m0);
    if (m0 != 4'd9)      f_inc_minutes = {m1, m0 + 4'd1};
    else if (m1 != 4'd5) f_inc_minutes = {m1 + 4'd1, 4'd0};
    else                 f_inc_minutes = {4'd0, 4'd0};
  endfunction

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h40;
      4'd1:    f_seg = 7'h79;
      4'd2:    f_seg = 7'h24;
      4'd3:    f_seg = 7'h30;
      4'd4:    f_seg = 7'h19;
      4'd5:    f_seg = 7'h12;
      4'd6:    f_seg = 7'h02;
      4'd7:    f_seg = 7'h78;
      4'd8:    f_seg = 7'h00;
      4'd9:    f_seg = 7'h10;
      default: f_seg = 7'h7F;
    endcase
  endfunction

  // Mode FSM, time registers, blink phase and button history.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_RUN;
      r_set_active <= 1'b0;
      r_blink      <= 1'b0;
      r_mode_d     <= 1'b0;
      r_inc_d      <= 1'b0;
      r_s0 <= 4'd0; r_s1 <= 4'd0;
      r_m0 <= 4'd0; r_m1 <= 4'd0;
      r_h0 <= 4'd0; r_h1 <= 4'd0;
    end else begin
      r_mode_d <= BTN_MODE;
      r_inc_d  <= BTN_INC;
      // Toggle by default; the forced clears below override it.
      if (TICK_BLINK) r_blink <= ~r_blink;
      case (r_state)
        ST_RUN: begin
          if (w_mode_edge) begin
            r_state      <= ST_SET_H;
            r_set_active <= 1'b1;
            r_blink      <= 1'b0;
            r_s0 <= 4'd0; r_s1 <= 4'd0;
          end else if (TICK_1HZ) begin
            if (r_s0 != 4'd9) r_s0 <= r_s0 + 4'd1;
            else begin
              r_s0 <= 4'd0;
              if (r_s1 != 4'd5) r_s1 <= r_s1 + 4'd1;
              else begin
                r_s1 <= 4'd0;
                if (r_m0 != 4'd9 || r_m1 != 4'd5) {r_m1, r_m0} <= f_inc_minutes(r_m1, r_m0);
                else begin
                  r_m1 <= 4'd0; r_m0 <= 4'd0;
                  {r_h1, r_h0} <= f_inc_hours(r_h1, r_h0);
                end
              end
            end
          end
        end
        ST_SET_H: begin
          if (w_mode_edge) begin
            r_state <= ST_SET_M;
            r_blink <= 1'b0;
          end else if (w_inc_edge) begin
            {r_h1, r_h0} <= f_inc_hours(r_h1, r_h0);
            r_blink      <= 1'b0;
          end
        end
        ST_SET_M: begin
          if (w_mode_edge) begin
            r_state      <= ST_RUN;
            r_set_active <= 1'b0;
            r_blink      <= 1'b0;
          end else if (w_inc_edge) begin
            {r_m1, r_m0} <= f_inc_minutes(r_m1, r_m0);
            r_blink      <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_RUN;
          r_set_active <= 1'b0;
        end
      endcase
    end
  end

  // Display stage: one cycle behind the time/state registers.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_disp_s0 <= 7'h40; r_disp_s1 <= 7'h40;
      r_disp_m0 <= 7'h40; r_disp_m1 <= 7'h40;
      r_disp_h0 <= 7'h40; r_disp_h1 <= 7'h40;
      r_en_h    <= 1'b0;
      r_en_m    <= 1'b0;
    end else begin
      r_disp_s0 <= f_seg(r_s0); r_disp_s1 <= f_seg(r_s1);
      r_disp_m0 <= f_seg(r_m0); r_disp_m1 <= f_seg(r_m1);
      r_disp_h0 <= f_seg(r_h0); r_disp_h1 <= f_seg(r_h1);
      r_en_h    <= (r_state == ST_SET_H) & r_blink;
      r_en_m    <= (r_state == ST_SET_M) & r_blink;
    end
  end

  assign DISPLAY_S0 = r_disp_s0;
  assign DISPLAY_S1 = r_disp_s1;
  assign DISPLAY_M0 = r_disp_m0;
  assign DISPLAY_M1 = r_disp_m1;
  assign DISPLAY_H0 = r_disp_h0;
  assign DISPLAY_H1 = r_disp_h1;
  // Seconds are never edited, so they never blink.
  assign EN_S0      = 1'b0;
  assign EN_S1      = 1'b0;
  assign EN_M0      = r_en_m;
  assign EN_M1      = r_en_m;
  assign EN_H0      = r_en_h;
  assign EN_H1      = r_en_h;
  assign SET_ACTIVE = r_set_active;

endmodule
`default_nettype wire

// File: tb/tb_watch_time_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_watch_time_core
// Purpose  : Self-checking bench for watch_time_core: table of tick vectors
//            plus directed sequences for set mode, blink, collisions, button
//            hold and asynchronous reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_watch_time_core;

  logic       CLK_IN = 1'b0;
  logic       RST_N = 1'b0;
  logic       TICK_1HZ = 1'b0;
  logic       TICK_BLINK = 1'b0;
  logic       BTN_MODE = 1'b0;
  logic       BTN_INC = 1'b0;
  logic [6:0] DISPLAY_S0, DISPLAY_S1, DISPLAY_M0, DISPLAY_M1, DISPLAY_H0, DISPLAY_H1;
  logic       EN_S0, EN_S1, EN_M0, EN_M1, EN_H0, EN_H1;
  logic       SET_ACTIVE;

  int n_cmp = 0;
  int n_fail = 0;

  watch_time_core u_dut (
    .CLK_IN(CLK_IN), .RST_N(RST_N),
    .TICK_1HZ(TICK_1HZ), .TICK_BLINK(TICK_BLINK),
    .BTN_MODE(BTN_MODE), .BTN_INC(BTN_INC),
    .DISPLAY_S0(DISPLAY_S0), .DISPLAY_S1(DISPLAY_S1),
    .DISPLAY_M0(DISPLAY_M0), .DISPLAY_M1(DISPLAY_M1),
    .DISPLAY_H0(DISPLAY_H0), .DISPLAY_H1(DISPLAY_H1),
    .EN_S0(EN_S0), .EN_S1(EN_S1), .EN_M0(EN_M0), .EN_M1(EN_M1),
    .EN_H0(EN_H0), .EN_H1(EN_H1),
    .SET_ACTIVE(SET_ACTIVE)
  );

  always #5 CLK_IN = ~CLK_IN;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: seg_ref = 7'h40;  1: seg_ref = 7'h79;  2: seg_ref = 7'h24;
      3: seg_ref = 7'h30;  4: seg_ref = 7'h19;  5: seg_ref = 7'h12;
      6: seg_ref = 7'h02;  7: seg_ref = 7'h78;  8: seg_ref = 7'h00;
      9: seg_ref = 7'h10;  default: seg_ref = 7'h7F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits one cycle so the display register catches up, then checks all digits.
  task automatic check_time(input string tag, input int h, input int m, input int s);
    @(negedge CLK_IN);
    chk({tag, " H1"}, DISPLAY_H1, seg_ref(h / 10));
    chk({tag, " H0"}, DISPLAY_H0, seg_ref(h % 10));
    chk({tag, " M1"}, DISPLAY_M1, seg_ref(m / 10));
    chk({tag, " M0"}, DISPLAY_M0, seg_ref(m % 10));
    chk({tag, " S1"}, DISPLAY_S1, seg_ref(s / 10));
    chk({tag, " S0"}, DISPLAY_S0, seg_ref(s % 10));
  endtask

  // One-cycle pulse on any combination of inputs, then one idle cycle's half.
  task automatic pulse(input logic t, input logic m, input logic i, input logic b);
    @(negedge CLK_IN);
    TICK_1HZ = t; BTN_MODE = m; BTN_INC = i; TICK_BLINK = b;
    @(negedge CLK_IN);
    TICK_1HZ = 1'b0; BTN_MODE = 1'b0; BTN_INC = 1'b0; TICK_BLINK = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic mode();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic blink();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  typedef struct {
    int n_ticks;
    int h;
    int m;
    int s;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 1};
    vecs[2] = '{8, 0, 0, 9};
    vecs[3] = '{1, 0, 0, 10};
    vecs[4] = '{39, 0, 0, 49};
    vecs[5] = '{10, 0, 0, 59};
    vecs[6] = '{1, 0, 1, 0};

    // Reset state
    repeat (2) @(negedge CLK_IN);
    chk("rst SET_ACTIVE", SET_ACTIVE, 0);
    chk("rst EN", {EN_H1, EN_H0, EN_M1, EN_M0, EN_S1, EN_S0}, 0);
    chk("rst S0", DISPLAY_S0, 7'h40);
    chk("rst H1", DISPLAY_H1, 7'h40);
    RST_N = 1'b1;

    // Tick table: 60 ticks total, 00:00:00 -> 00:01:00
    for (int v = 0; v < 7; v++) begin
      ticks(vecs[v].n_ticks);
      check_time($sformatf("vec%0d", v), vecs[v].h, vecs[v].m, vecs[v].s);
      chk($sformatf("vec%0d SET_ACTIVE", v), SET_ACTIVE, 0);
    end

    // INC ignored in RUN
    incs(1);
    check_time("run inc", 0, 1, 0);

    // MODE; INC x25; MODE; INC x61; MODE, with ticks during set
    RST_N = 1'b0;
    @(negedge CLK_IN);
    RST_N = 1'b1;
    mode();
    chk("seq SET_ACTIVE a", SET_ACTIVE, 1);
    incs(10); ticks(3); incs(15);
    mode();
    chk("seq SET_ACTIVE b", SET_ACTIVE, 1);
    incs(30); ticks(2); incs(31);
    mode();
    chk("seq SET_ACTIVE c", SET_ACTIVE, 0);
    check_time("seq", 1, 1, 0);

    // Preload 23:59:58 then wrap through midnight
    mode(); incs(22); mode(); incs(58); mode();
    ticks(58);
    check_time("pre", 23, 59, 58);
    ticks(1);
    check_time("pre+1", 23, 59, 59);
    ticks(1);
    check_time("midnight", 0, 0, 0);

    // Blink in SET_M
    mode(); mode();
    chk("blk SET_ACTIVE", SET_ACTIVE, 1);
    blink(); @(negedge CLK_IN);
    chk("blk1 EN_M0", EN_M0, 1); chk("blk1 EN_M1", EN_M1, 1);
    blink(); @(negedge CLK_IN);
    chk("blk2 EN_M0", EN_M0, 0);
    blink(); @(negedge CLK_IN);
    chk("blk3 EN_M0", EN_M0, 1); chk("blk3 EN_M1", EN_M1, 1);
    chk("blk3 EN_H/S", {EN_H1, EN_H0, EN_S1, EN_S0}, 0);
    incs(1); @(negedge CLK_IN);
    chk("blk inc EN_M0", EN_M0, 0); chk("blk inc EN_M1", EN_M1, 0);
    chk("blk inc M0", DISPLAY_M0, 7'h79);

    // Same-cycle MODE+INC in SET_H -> SET_M, hours unchanged
    mode(); mode();
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    chk("mi SET_ACTIVE", SET_ACTIVE, 1);
    blink(); @(negedge CLK_IN);
    chk("mi EN_M0", EN_M0, 1);
    chk("mi EN_H0", EN_H0, 0);
    check_time("mi", 0, 1, 0);
    mode();

    // Same-cycle TICK+MODE in RUN at 12:34:56 and in SET_M
    mode(); incs(12); mode(); incs(33); mode();
    ticks(56);
    check_time("tm pre", 12, 34, 56);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tm run SET_ACTIVE", SET_ACTIVE, 1);
    check_time("tm run", 12, 34, 0);
    mode();
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tm setm SET_ACTIVE", SET_ACTIVE, 0);
    check_time("tm setm", 12, 34, 0);
    ticks(1);
    check_time("tm resume", 12, 34, 1);

    // Held INC in SET_H gives exactly one increment
    mode();
    @(negedge CLK_IN);
    BTN_INC = 1'b1;
    repeat (100) @(negedge CLK_IN);
    BTN_INC = 1'b0;
    check_time("hold", 13, 34, 0);
    blink(); @(negedge CLK_IN);
    chk("hold EN_H0", EN_H0, 1); chk("hold EN_H1", EN_H1, 1);

    // Asynchronous reset between edges
    #2 RST_N = 1'b0;
    #1;
    chk("arst SET_ACTIVE", SET_ACTIVE, 0);
    chk("arst EN", {EN_H1, EN_H0, EN_M1, EN_M0, EN_S1, EN_S0}, 0);
    chk("arst DISP", {DISPLAY_H1, DISPLAY_H0, DISPLAY_M1, DISPLAY_M0, DISPLAY_S1, DISPLAY_S0},
        {6{7'h40}});
    @(negedge CLK_IN);
    RST_N = 1'b1;
    ticks(1);
    check_time("post arst", 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
